t07_spi_tft_tx: RTL and testbench

SPI master transmitter for the TFT display, directly downstream of the MMIO decoder. It accepts one display write (`displayWrite`, `displayAddr`, `displayData`) from the MMIO, serialises 1–4 bytes onto a mode-0 SPI link with a D/C line, and drives `busyTFT` back to the MMIO so the CPU stalls until the frame is on the wire.

---
 rtl/t07_spi_tft_tx.sv | 120 ++++++++++++
 tb/tb_t07_spi_tft_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t07_spi_tft_tx.sv
// Mode-0 SPI transmitter for the TFT panel: takes one MMIO display write, shifts out
// 1-4 bytes MSB first with a D/C line, and stalls the CPU via busyTFT_o until done.
module t07_spi_tft_tx #(
    parameter int HALF_PERIOD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        displayWrite,
    input  logic [31:0] displayAddr,
    input  logic [31:0] displayData,
    output logic        busyTFT_o,
    output logic        tft_sclk,
    output logic        tft_mosi,
    output logic        tft_cs_n,
    output logic        tft_dc
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        WAIT_REL
    } state_t;

    localparam logic [7:0] HP_M1 = 8'(HALF_PERIOD - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hcnt;
    logic [5:0]  r_bitcnt;
    logic [31:0] r_shift;
    logic        r_armed;

    logic        w_tick;
    logic        w_enter;
    logic        w_accept;
    logic        w_hi_to_lo;
    logic [4:0]  w_shamt;
    logic [31:0] w_load;
    logic        w_unused_addr;

    assign w_unused_addr = ^displayAddr[31:3];

    assign w_tick     = (r_hcnt == 8'd0);
    assign w_enter    = (w_state_nxt != r_state);
    assign w_accept   = (r_state == IDLE) && displayWrite && r_armed;
    assign w_hi_to_lo = (r_state == SHIFT_HI) && (w_state_nxt == SHIFT_LO);
    // Left-align so the first byte to go out lands in [31:24].
    assign w_shamt    = {2'd3 - displayAddr[1:0], 3'b000};
    assign w_load     = displayData << w_shamt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (displayWrite && r_armed) w_state_nxt = SETUP;
            SETUP:    if (w_tick) w_state_nxt = SHIFT_HI;
            SHIFT_HI: if (w_tick) w_state_nxt = SHIFT_LO;
            SHIFT_LO: if (w_tick) w_state_nxt = (r_bitcnt == 6'd0) ? HOLD : SHIFT_HI;
            HOLD:     if (w_tick) w_state_nxt = WAIT_REL;
            WAIT_REL: if (!displayWrite) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_armed   <= 1'b1;
            r_hcnt    <= HP_M1;
            busyTFT_o <= 1'b0;
            tft_sclk  <= 1'b0;
            tft_mosi  <= 1'b0;
            tft_cs_n  <= 1'b1;
            tft_dc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_enter)
                r_hcnt <= HP_M1;
            else if (r_hcnt != 8'd0)
                r_hcnt <= r_hcnt - 8'd1;

            if (r_state == HOLD && w_tick)
                r_armed <= 1'b0;
            else if (r_state == WAIT_REL && !displayWrite)
                r_armed <= 1'b1;

            busyTFT_o <= (w_state_nxt == SETUP) || (w_state_nxt == SHIFT_HI) ||
                         (w_state_nxt == SHIFT_LO) || (w_state_nxt == HOLD);
            tft_cs_n  <= !((w_state_nxt == SETUP) || (w_state_nxt == SHIFT_HI) ||
                           (w_state_nxt == SHIFT_LO));
            tft_sclk  <= (w_state_nxt == SHIFT_HI);

            if (w_accept)
                tft_mosi <= w_load[31];
            else if (w_hi_to_lo)
                tft_mosi <= r_shift[30];
            else if (w_state_nxt == HOLD || w_state_nxt == WAIT_REL || w_state_nxt == IDLE)
                tft_mosi <= 1'b0;

            if (w_accept)
                tft_dc <= displayAddr[2];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shift  <= w_load;
            r_bitcnt <= {1'b0, displayAddr[1:0], 3'b111};
        end else if (w_hi_to_lo) begin
            r_shift <= {r_shift[30:0], 1'b0};
        end else if (r_state == SHIFT_LO && w_tick && r_bitcnt != 6'd0) begin
            r_bitcnt <= r_bitcnt - 6'd1;
        end
    end

endmodule

// File: tb/tb_t07_spi_tft_tx.sv
// Directed bench for t07_spi_tft_tx: one instance at HALF_PERIOD=2, one at HALF_PERIOD=1,
// each watched by a small SPI receiver model.
module tb_t07_spi_tft_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: HALF_PERIOD = 2
    logic        dw_a = 1'b0;
    logic [31:0] addr_a = '0;
    logic [31:0] data_a = '0;
    logic        busy_a, sclk_a, mosi_a, cs_a, dc_a;

    // Instance B: HALF_PERIOD = 1
    logic        dw_b = 1'b0;
    logic [31:0] addr_b = '0;
    logic [31:0] data_b = '0;
    logic        busy_b, sclk_b, mosi_b, cs_b, dc_b;

    t07_spi_tft_tx #(.HALF_PERIOD(2)) u_dut_a (
        .clk(clk), .rst(rst), .displayWrite(dw_a), .displayAddr(addr_a), .displayData(data_a),
        .busyTFT_o(busy_a), .tft_sclk(sclk_a), .tft_mosi(mosi_a), .tft_cs_n(cs_a), .tft_dc(dc_a)
    );

    t07_spi_tft_tx #(.HALF_PERIOD(1)) u_dut_b (
        .clk(clk), .rst(rst), .displayWrite(dw_b), .displayAddr(addr_b), .displayData(data_b),
        .busyTFT_o(busy_b), .tft_sclk(sclk_b), .tft_mosi(mosi_b), .tft_cs_n(cs_b), .tft_dc(dc_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver models
    logic        clr = 1'b1;
    int          cyc = 0;
    logic [31:0] rx_a = '0;
    int          nbits_a = 0, busy_cnt_a = 0, frames_a = 0, dc1_a = 0, setup_a = 0, fall_cyc_a = 0;
    logic        prev_sclk_a = 1'b0, prev_cs_a = 1'b1;

    logic [31:0] rx_b = '0;
    int          nbits_b = 0, frames_b = 0, bad_per_b = 0, last_rise_b = 0, hi_run_b = 0;
    int          min_gap_b = 1000;
    logic        have_rise_b = 1'b0;
    logic        prev_sclk_b = 1'b0, prev_cs_b = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_sclk_a <= sclk_a;
        prev_cs_a   <= cs_a;
        prev_sclk_b <= sclk_b;
        prev_cs_b   <= cs_b;
        if (clr) begin
            rx_a <= '0; nbits_a <= 0; busy_cnt_a <= 0; frames_a <= 0; dc1_a <= 0; setup_a <= 0;
            rx_b <= '0; nbits_b <= 0; frames_b <= 0; bad_per_b <= 0; hi_run_b <= 0;
            min_gap_b <= 1000; have_rise_b <= 1'b0;
        end else begin
            if (busy_a === 1'b1) busy_cnt_a <= busy_cnt_a + 1;
            if (cs_a === 1'b0 && prev_cs_a === 1'b1) begin
                frames_a   <= frames_a + 1;
                fall_cyc_a <= cyc;
            end
            if (sclk_a === 1'b1 && prev_sclk_a === 1'b0 && cs_a === 1'b0) begin
                rx_a    <= {rx_a[30:0], mosi_a};
                nbits_a <= nbits_a + 1;
                if (dc_a === 1'b1) dc1_a <= dc1_a + 1;
                if (nbits_a == 0) setup_a <= cyc - fall_cyc_a;
            end

            if (cs_b === 1'b1) hi_run_b <= hi_run_b + 1;
            if (cs_b === 1'b0 && prev_cs_b === 1'b1) begin
                frames_b <= frames_b + 1;
                if (frames_b > 0 && hi_run_b < min_gap_b) min_gap_b <= hi_run_b;
                hi_run_b    <= 0;
                have_rise_b <= 1'b0;
            end
            if (sclk_b === 1'b1 && prev_sclk_b === 1'b0 && cs_b === 1'b0) begin
                rx_b    <= {rx_b[30:0], mosi_b};
                nbits_b <= nbits_b + 1;
                if (have_rise_b && (cyc - last_rise_b) != 2) bad_per_b <= bad_per_b + 1;
                have_rise_b <= 1'b1;
                last_rise_b <= cyc;
            end
        end
    end

    task automatic clear_mon();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Wait for busy to rise (if not already) and then fall, bounded.
    task automatic wait_frame_a(input string tag);
        int   n;
        logic to;
        n  = 0;
        to = 1'b0;
        while (busy_a !== 1'b1 && n < 50) begin tick(); n++; end
        if (busy_a !== 1'b1) to = 1'b1;
        while (busy_a === 1'b1 && n < 400) begin tick(); n++; end
        if (busy_a === 1'b1) to = 1'b1;
        check_eq({tag, "_timeout"}, {31'b0, to}, 32'd0);
    endtask

    task automatic wait_frame_b(input string tag);
        int   n;
        logic to;
        n  = 0;
        to = 1'b0;
        while (busy_b !== 1'b1 && n < 50) begin tick(); n++; end
        if (busy_b !== 1'b1) to = 1'b1;
        while (busy_b === 1'b1 && n < 200) begin tick(); n++; end
        if (busy_b === 1'b1) to = 1'b1;
        check_eq({tag, "_timeout"}, {31'b0, to}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset
        rst = 1'b1;
        tick(); tick(); tick();
        check_eq("rst_sclk", {31'b0, sclk_a}, 32'd0);
        check_eq("rst_mosi", {31'b0, mosi_a}, 32'd0);
        check_eq("rst_cs_n", {31'b0, cs_a},   32'd1);
        check_eq("rst_dc",   {31'b0, dc_a},   32'd0);
        check_eq("rst_busy", {31'b0, busy_a}, 32'd0);
        check_eq("rst_cs_n_b", {31'b0, cs_b}, 32'd1);
        rst = 1'b0;
        tick();
        clear_mon();

        // 1-byte data frame
        dw_a = 1'b1; addr_a = 32'h704; data_a = 32'h0000_00A5;
        tick();
        check_eq("f1_cs_at_accept",   {31'b0, cs_a},   32'd0);
        check_eq("f1_busy_at_accept", {31'b0, busy_a}, 32'd1);
        wait_frame_a("f1");
        check_eq("f1_rx",     rx_a & 32'hFF, 32'hA5);
        check_eq("f1_nbits",  nbits_a,       32'd8);
        check_eq("f1_busy",   busy_cnt_a,    32'd36);
        check_eq("f1_dc",     dc1_a,         32'd8);
        check_eq("f1_setup",  setup_a,       32'd2);
        check_eq("f1_frames", frames_a,      32'd1);
        dw_a = 1'b0;
        tick(); tick();
        clear_mon();

        // 4-byte command frame
        dw_a = 1'b1; addr_a = 32'h703; data_a = 32'hDEAD_BEEF;
        wait_frame_a("f4");
        check_eq("f4_rx",    rx_a,       32'hDEAD_BEEF);
        check_eq("f4_nbits", nbits_a,    32'd32);
        check_eq("f4_busy",  busy_cnt_a, 32'd132);
        check_eq("f4_dc",    dc1_a,      32'd0);
        check_eq("f4_dc_pin", {31'b0, dc_a}, 32'd0);
        dw_a = 1'b0;
        tick(); tick();
        clear_mon();

        // Level-held request gives one frame; drop and re-raise gives a second
        dw_a = 1'b1; addr_a = 32'h700; data_a = 32'h5A;
        for (int i = 0; i < 100; i++) tick();
        check_eq("lvl_frames1", frames_a, 32'd1);
        check_eq("lvl_nbits1",  nbits_a,  32'd8);
        dw_a = 1'b0;
        tick(); tick();
        dw_a = 1'b1;
        wait_frame_a("lvl2");
        check_eq("lvl_frames2", frames_a,       32'd2);
        check_eq("lvl_rx",      rx_a & 32'hFFFF, 32'h5A5A);
        dw_a = 1'b0;
        tick(); tick();
        clear_mon();

        // Payload latched at accept
        dw_a = 1'b1; addr_a = 32'h700; data_a = 32'h3C;
        tick();
        tick(); tick();
        data_a = 32'hFF;
        wait_frame_a("latch");
        check_eq("latch_rx", rx_a & 32'hFF, 32'h3C);
        dw_a = 1'b0;
        tick(); tick();
        clear_mon();

        // Reset during the 5th bit of a 2-byte frame
        dw_a = 1'b1; addr_a = 32'h701; data_a = 32'h1234;
        n = 0;
        while (nbits_a < 5 && n < 200) begin tick(); n++; end
        check_eq("mid_reached_bit5", nbits_a, 32'd5);
        rst = 1'b1; dw_a = 1'b0;
        tick();
        check_eq("mid_cs_n", {31'b0, cs_a},   32'd1);
        check_eq("mid_sclk", {31'b0, sclk_a}, 32'd0);
        check_eq("mid_busy", {31'b0, busy_a}, 32'd0);
        rst = 1'b0;
        tick();
        clear_mon();
        dw_a = 1'b1; addr_a = 32'h701; data_a = 32'hBEEF;
        wait_frame_a("post_rst");
        check_eq("post_rst_rx",    rx_a & 32'hFFFF, 32'hBEEF);
        check_eq("post_rst_nbits", nbits_a,         32'd16);
        check_eq("post_rst_busy",  busy_cnt_a,      32'd68);
        dw_a = 1'b0;
        tick(); tick();
        clear_mon();

        // HALF_PERIOD=1 back-to-back frames
        dw_b = 1'b1; addr_b = 32'h700; data_b = 32'h81;
        wait_frame_b("b2b1");
        dw_b = 1'b0;
        tick();
        dw_b = 1'b1; addr_b = 32'h701; data_b = 32'hC33C;
        wait_frame_b("b2b2");
        dw_b = 1'b0;
        tick(); tick();
        check_eq("b2b_frames",  frames_b,           32'd2);
        check_eq("b2b_nbits",   nbits_b,            32'd24);
        check_eq("b2b_rx",      rx_b & 32'hFF_FFFF, 32'h81_C33C);
        check_eq("b2b_period",  bad_per_b,          32'd0);
        check_eq("b2b_gap_ok",  {31'b0, (min_gap_b >= 1) && (min_gap_b < 1000)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
